sdu_rx_averager: RTL
====================

// Module: sdu_rx_averager
// PURPOSE
//  Receive-side consumer of the SDUltrasound sequencer's tx_en/rx_en/seq_done/ave_done controls.
//  Coherently sums echo samples captured while sdu_rx_en is high, across all sequences of one average.
//  On sdu_ave_done_strobe it drains the scaled sums as one framed packet to the host RX FIFO.
//  Sits between the DSP RX chain and the RX packet path.
// PARAMETERS
//  BASE      0    settings-bus address of this block's single register
//  AWIDTH    12   log2 of accumulator depth; max samples per sequence = 2**AWIDTH
//  ACCW      32   accumulator width per I or Q component (signed)
// PORTS
//  clk               in   1     system clock
//  reset             in   1     asynchronous, active-high reset
//  set_stb           in   1     settings write strobe
//  set_addr          in   8     settings address
//  set_data          in   32    settings data
//  sdu_rx_en         in   1     receive window from sequencer
//  sdu_seq_done_strobe in 1     one-cycle end-of-sequence pulse
//  sdu_ave_done_strobe in 1     one-cycle end-of-average pulse (coincides with a seq_done)
//  sample            in   32    {I[31:16], Q[15:0]}, signed 16-bit each
//  sample_strobe     in   1     sample valid
//  data_o            out  34    {eof, sof, I[15:0], Q[15:0]}
//  src_rdy_o         out  1     output word valid
//  dst_rdy_i         in   1     downstream ready; transfer when src_rdy_o & dst_rdy_i
//  busy_o            out  1     high in any state other than IDLE
//  overrun_o         out  1     sticky: sample dropped (drain active or index past depth)
// BEHAVIOUR
//  Register BASE+0: [4:0] shift, [8] arm, [9] clear_overrun (self-clearing, write-only).
//  Reset: state=IDLE, data_o=0, src_rdy_o=0, busy_o=0, overrun_o=0, idx=0, shift=0, arm=0.
//  Accepted sample = sample_strobe & sdu_rx_en in FIRST or ACCUM; other strobes ignored.
//  States:
//   IDLE : arm=1 -> FIRST on the next seq_done (aligns to sequence boundary).
//   FIRST: acc[idx] <= sext(sample); idx++ per accepted sample.
//          seq_done -> ACCUM, idx<=0; seq_done&ave_done -> DRAIN (single-sequence average).
//   ACCUM: acc[idx] <= acc[idx] + sext(sample) (read-modify-write, RAM 1-cycle read, pipelined
//          with forwarding so back-to-back strobes at the same idx are impossible yet consecutive
//          idx at full rate are sustained). seq_done -> idx<=0; seq_done&ave_done -> DRAIN.
//   DRAIN: len latched = idx at ave_done, counting a sample accepted in that same cycle.
//          Emit len words, word k = sat16((accI[k]) >>> shift), same for Q; sof on k=0, eof on k=len-1.
//          len=0 -> no words, straight back. data_o stable while src_rdy_o & !dst_rdy_i.
//          After final transfer: arm=1 -> FIRST on next seq_done; arm=0 -> IDLE.
//  Simultaneous sample_strobe & seq_done: sample uses current idx, then idx resets.
//  idx == 2**AWIDTH: further samples in that sequence dropped, overrun_o set; no wrap.
//  Accepted-window sample while in DRAIN: dropped, overrun_o set.
//  arm=0 written mid-FIRST/ACCUM: -> IDLE next cycle, sums discarded. arm=0 mid-DRAIN: frame
//  completes, then IDLE. Async reset mid-frame: src_rdy_o drops immediately.
//  Arithmetic: sums wrap at ACCW (host chooses shift/num_ave to avoid); >>> arithmetic.
//  sat16 clamps to [-32768, 32767]. clear_overrun and a new overrun same cycle: overrun wins.
//  Latency: ave_done to first src_rdy_o = 2 cycles.
// CONFIGURATION
//  SDU_RXAVE_ROUND_EN defined: add 1<<(shift-1) before the shift (round half up; none when
//  shift=0). Undefined: plain truncation toward -inf.
// STRUCTURE
//  Shared header sdu_defs.vh: register offset, field bit positions, state encodings
//  (IDLE/FIRST/ACCUM/DRAIN), sat16 function. Reused by sdu_controller-side code.
//  Sub-module sdu_acc_ram: simple dual-port RAM, 2**AWIDTH x 2*ACCW, sync read 1 cycle.
// TESTING
//  arm, shift=0, 1 seq of 4 samples (1,2,3,4 on I) with ave_done -> one frame I=1,2,3,4, sof/eof.
//  arm, shift=2, 4 seqs each I=+100,-100 -> frame I=100,-100; ROUND_EN with I=102 x4 gives 102 too.
//  16 seqs of I=32767, shift=0 -> output saturates at 32767; Q=-32768 -> -32768.
//  dst_rdy_i toggled 1/0 during drain -> no lost/duplicated words, data_o held while stalled.
//  samples during DRAIN and 2**AWIDTH+1 samples in a sequence -> overrun_o=1; clear -> 0.
//  arm=0 mid-ACCUM -> IDLE, no frame; arm=0 mid-DRAIN -> frame finishes then IDLE.

Source files
------------

// File: rtl/sdu_rx_averager_pkg.sv
// rtl/sdu_rx_averager_pkg.sv - shared register map, state encoding and saturation helper for the RX averager
package sdu_rx_averager_pkg;

    localparam logic [7:0] REG_CTRL_OFF = 8'd0;
    localparam int         SHIFT_LSB    = 0;
    localparam int         SHIFT_W      = 5;
    localparam int         ARM_BIT      = 8;
    localparam int         CLR_OVR_BIT  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Clamp a wide signed value into the signed 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'h7fff;
        end else if (v < -64'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/sdu_rx_averager_acc_ram.sv
// rtl/sdu_rx_averager_acc_ram.sv - simple dual-port accumulator RAM, synchronous read, read-before-write
module sdu_rx_averager_acc_ram #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem [0:(2**AWIDTH)-1];
    logic [DWIDTH-1:0] rdata_q;

    // A read of the address being written this cycle returns the old word; the caller forwards.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdu_rx_averager.sv
// rtl/sdu_rx_averager.sv - coherent multi-sequence echo averager with framed drain; SDU_RXAVE_ROUND_EN selects round-half-up
module sdu_rx_averager #(
    parameter logic [7:0] BASE   = 8'd0,
    parameter int         AWIDTH = 12,
    parameter int         ACCW   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        sdu_rx_en,
    input  logic        sdu_seq_done_strobe,
    input  logic        sdu_ave_done_strobe,
    input  logic [31:0] sample,
    input  logic        sample_strobe,
    output logic [33:0] data_o,
    output logic        src_rdy_o,
    input  logic        dst_rdy_i,
    output logic        busy_o,
    output logic        overrun_o
);
    import sdu_rx_averager_pkg::*;

    localparam int             IW    = AWIDTH + 1;
    localparam int             DW    = 2 * ACCW;
    localparam logic [IW-1:0]  DEPTH = {1'b1, {AWIDTH{1'b0}}};

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, len_q, len_d, k_q, k_d;
    logic              src_rdy_q, src_rdy_d;
    logic [4:0]        shift_q;
    logic              arm_q, overrun_q;

    logic              reg_wr, window, in_acc, take, ovr_set, xfer, last_word;
    logic [AWIDTH-1:0] raddr;

    logic              p1_vld_q, p1_first_q, lw_vld_q;
    logic [AWIDTH-1:0] p1_addr_q, rd_addr_q, lw_addr_q;
    logic [15:0]       p1_i_q, p1_s_q;
    logic [DW-1:0]     rd_data, fwd_data, wr_data, lw_data_q;
    logic [ACCW-1:0]   sext_i, sext_q;
    logic              unused_set_bits;

    function automatic logic [ACCW-1:0] sext(input logic [15:0] v);
        return {{(ACCW-16){v[15]}}, v};
    endfunction

    function automatic logic [15:0] scale(input logic [ACCW-1:0] acc, input logic [4:0] sh);
        logic signed [ACCW-1:0] v;
        v = acc;
`ifdef SDU_RXAVE_ROUND_EN
        if (sh != 5'd0) begin
            v = v + (ACCW'(1) << (sh - 5'd1));
        end
`endif
        v = v >>> sh;
        return sat16({{(64-ACCW){v[ACCW-1]}}, v});
    endfunction

    assign reg_wr    = set_stb && (set_addr == BASE + REG_CTRL_OFF);
    assign window    = sample_strobe && sdu_rx_en;
    assign in_acc    = (state_q == ST_FIRST) || (state_q == ST_ACCUM);
    assign take      = window && in_acc && (idx_q != DEPTH);
    assign ovr_set   = window && ((in_acc && (idx_q == DEPTH)) || (state_q == ST_DRAIN));
    assign xfer      = src_rdy_q && dst_rdy_i;
    assign last_word = (k_q == len_q - 1'b1);

    // FSM and index/length/drain-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            k_q       <= '0;
            src_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            k_q       <= k_d;
            src_rdy_q <= src_rdy_d;
        end
    end

    // Next-state: sequence alignment, sample indexing, and drain handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        k_d       = k_q;
        src_rdy_d = src_rdy_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (arm_q && sdu_seq_done_strobe) begin
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST, ST_ACCUM: begin
                if (take) begin
                    idx_d = idx_q + 1'b1;
                end
                if (!arm_q) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (sdu_seq_done_strobe) begin
                    idx_d = '0;
                    if (sdu_ave_done_strobe) begin
                        state_d   = ST_DRAIN;
                        len_d     = take ? idx_q + 1'b1 : idx_q;
                        k_d       = '0;
                        src_rdy_d = 1'b0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DRAIN: begin
                if (!src_rdy_q) begin
                    if (len_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        src_rdy_d = 1'b1;
                    end
                end else if (xfer) begin
                    if (last_word) begin
                        src_rdy_d = 1'b0;
                        k_d       = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drain reads the word that will be presented next cycle, so a stall re-reads the same word.
    assign raddr = (state_q == ST_DRAIN) ? k_d[AWIDTH-1:0] : idx_q[AWIDTH-1:0];

    // Settings register and sticky overrun; a new overrun beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            arm_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (reg_wr) begin
                shift_q <= set_data[SHIFT_LSB +: SHIFT_W];
                arm_q   <= set_data[ARM_BIT];
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (reg_wr && set_data[CLR_OVR_BIT]) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Read-modify-write pipeline: read at accept, add and write one cycle later, remember the last write for forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_vld_q   <= 1'b0;
            p1_first_q <= 1'b0;
            p1_addr_q  <= '0;
            p1_i_q     <= '0;
            p1_s_q     <= '0;
            rd_addr_q  <= '0;
            lw_vld_q   <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
        end else begin
            p1_vld_q   <= take;
            p1_first_q <= (state_q == ST_FIRST);
            p1_addr_q  <= idx_q[AWIDTH-1:0];
            p1_i_q     <= sample[31:16];
            p1_s_q     <= sample[15:0];
            rd_addr_q  <= raddr;
            lw_vld_q   <= p1_vld_q;
            lw_addr_q  <= p1_addr_q;
            lw_data_q  <= wr_data;
        end
    end

    // The RAM returns pre-write data when read and written in the same cycle; patch that case.
    assign fwd_data = (lw_vld_q && (lw_addr_q == rd_addr_q)) ? lw_data_q : rd_data;
    assign sext_i   = sext(p1_i_q);
    assign sext_q   = sext(p1_s_q);
    assign wr_data  = p1_first_q ? {sext_i, sext_q}
                                 : {fwd_data[DW-1:ACCW] + sext_i, fwd_data[ACCW-1:0] + sext_q};

    sdu_rx_averager_acc_ram #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DW)
    ) u_acc_ram (
        .clk     (clk),
        .we_i    (p1_vld_q),
        .waddr_i (p1_addr_q),
        .wdata_i (wr_data),
        .raddr_i (raddr),
        .rdata_o (rd_data)
    );

    assign data_o    = src_rdy_q ? {last_word, (k_q == '0),
                                    scale(fwd_data[DW-1:ACCW], shift_q),
                                    scale(fwd_data[ACCW-1:0], shift_q)} : '0;
    assign src_rdy_o = src_rdy_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;

    assign unused_set_bits = ^{set_data[31:10], set_data[7:5]};

endmodule
